// File: rtl/d_debounce_sync_if.sv
// Signal bundle between the raw input source and the debounce/synchroniser stage.
// rise/fall are single-cycle valid strobes with no ready: the consumer must sample them on the cycle they are high.
interface d_debounce_sync_if;
   logic       din;
   logic       d;
   logic       dpar;
   logic       rise;
   logic       fall;
   logic [7:0] edge_cnt;
   logic [1:0] state;

   modport master (output din, input d, dpar, rise, fall, edge_cnt, state);
   modport slave  (input din, output d, dpar, rise, fall, edge_cnt, state);
endinterface

// File: rtl/d_debounce_sync.sv
// Two-flop synchroniser followed by a stability-counter debounce FSM producing a clean
// registered level, its complement, rise/fall strobes and a wrapping rising-edge count.
module d_debounce_sync #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic               clk,
   input logic               rest,
   d_debounce_sync_if.slave  bus
);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             s1, s2;
   logic             d, d_n;
   logic             dpar;
   logic             rise, rise_n;
   logic             fall, fall_n;
   logic [7:0]       edge_cnt, edge_cnt_n;

   always_ff @(posedge clk) begin
      if (rest) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         state    <= LOW;
         cnt      <= '0;
         d        <= 1'b0;
         dpar     <= 1'b1;
         rise     <= 1'b0;
         fall     <= 1'b0;
         edge_cnt <= 8'd0;
      end else begin
         s1       <= bus.din;
         s2       <= s1;
         state    <= state_n;
         cnt      <= cnt_n;
         d        <= d_n;
         dpar     <= ~d_n;
         rise     <= rise_n;
         fall     <= fall_n;
         edge_cnt <= edge_cnt_n;
      end
   end

   // The sample that enters a WAIT state counts as the first of STABLE_CYCLES.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      d_n        = d;
      rise_n     = 1'b0;
      fall_n     = 1'b0;
      edge_cnt_n = edge_cnt;
      case (state)
         LOW: begin
            if (s2) begin
               state_n = WAIT_HIGH;
               cnt_n   = CNT_W'(1);
            end
         end
         WAIT_HIGH: begin
            if (!s2) begin
               state_n = LOW;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n    = HIGH;
               cnt_n      = '0;
               d_n        = 1'b1;
               rise_n     = 1'b1;
               edge_cnt_n = edge_cnt + 8'd1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s2) begin
               state_n = WAIT_LOW;
               cnt_n   = CNT_W'(1);
            end
         end
         WAIT_LOW: begin
            if (s2) begin
               state_n = HIGH;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = LOW;
               cnt_n   = '0;
               d_n     = 1'b0;
               fall_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = LOW;
            cnt_n   = '0;
         end
      endcase
   end

   assign bus.d        = d;
   assign bus.dpar     = dpar;
   assign bus.rise     = rise;
   assign bus.fall     = fall;
   assign bus.edge_cnt = edge_cnt;
   assign bus.state    = state;

endmodule

// File: tb/tb_d_debounce_sync.sv
// Directed bench: stimulus pushes expected strobes (kind, cycle, edge count) into a queue;
// a negedge monitor pops and compares whenever rise or fall is presented.
module tb_d_debounce_sync;

   localparam int W = 29;

   logic clk;
   logic rest;
   int   cyc;
   int   checks;
   int   failures;
   int   n_rise;
   int   n_fall;
   logic [W-1:0] exp_q[$];

   d_debounce_sync_if bus ();

   d_debounce_sync #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk  (clk),
      .rest (rest),
      .bus  (bus.slave)
   );

   // clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // kind: 1 = rise, 0 = fall; at = edge index where the strobe is registered
   task automatic expect_strobe(input bit kind, input int at, input int ecnt);
      logic [W-1:0] e;
      e = {kind, 8'(ecnt), 20'(at)};
      exp_q.push_back(e);
   endtask

   task automatic drain_check(input string name);
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (bus.rise) n_rise = n_rise + 1;
      if (bus.fall) n_fall = n_fall + 1;
      if (bus.rise && bus.fall) chk("rise_fall_together", 1, 0);
      if (bus.rise || bus.fall) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {31'd0, bus.rise}, 2);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", {31'd0, bus.rise}, {31'd0, e[28]});
            chk("strobe_cycle", cyc, {12'd0, e[19:0]});
            chk("strobe_edge_cnt", {24'd0, bus.edge_cnt}, {24'd0, e[27:20]});
            chk("strobe_d", {31'd0, bus.d}, {31'd0, e[28]});
            chk("strobe_dpar", {31'd0, bus.dpar}, {31'd0, ~e[28]});
         end
      end
   end

   initial begin
      int k;
      bit bounce[9];
      checks   = 0;
      failures = 0;
      n_rise   = 0;
      n_fall   = 0;
      rest     = 1'b1;
      bus.din  = 1'b1;

      // reset values with din held high
      tick(2);
      chk("reset_d", {31'd0, bus.d}, 0);
      chk("reset_dpar", {31'd0, bus.dpar}, 1);
      chk("reset_rise", {31'd0, bus.rise}, 0);
      chk("reset_fall", {31'd0, bus.fall}, 0);
      chk("reset_edge_cnt", {24'd0, bus.edge_cnt}, 0);
      chk("reset_state", {30'd0, bus.state}, 0);

      // clean rise
      rest    = 1'b0;
      bus.din = 1'b0;
      tick(4);
      bus.din = 1'b1;
      k = cyc;
      expect_strobe(1'b1, k + 6, 1);
      tick(10);
      chk("clean_rise_d", {31'd0, bus.d}, 1);
      chk("clean_rise_dpar", {31'd0, bus.dpar}, 0);
      chk("clean_rise_edge_cnt", {24'd0, bus.edge_cnt}, 1);
      drain_check("clean_rise_pending");

      // short low pulse rejected, then real fall
      bus.din = 1'b0;
      tick(3);
      bus.din = 1'b1;
      tick(10);
      chk("short_low_d", {31'd0, bus.d}, 1);
      bus.din = 1'b0;
      k = cyc;
      expect_strobe(1'b0, k + 6, 1);
      tick(10);
      chk("fall_d", {31'd0, bus.d}, 0);
      chk("fall_dpar", {31'd0, bus.dpar}, 1);
      chk("fall_edge_cnt", {24'd0, bus.edge_cnt}, 1);
      drain_check("fall_pending");

      // bounce rejection from a fresh reset
      rest = 1'b1;
      tick(2);
      rest = 1'b0;
      tick(4);
      bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
      k = cyc;
      // last low is sampled at edge k+5, so the stable run starts at E0 = k+6
      expect_strobe(1'b1, k + 11, 1);
      for (int i = 0; i < 9; i++) begin
         bus.din = bounce[i];
         tick(1);
      end
      tick(10);
      chk("bounce_d", {31'd0, bus.d}, 1);
      chk("bounce_edge_cnt", {24'd0, bus.edge_cnt}, 1);
      drain_check("bounce_pending");

      // back to low, then reset mid-WAIT_HIGH
      bus.din = 1'b0;
      k = cyc;
      expect_strobe(1'b0, k + 6, 1);
      tick(10);
      drain_check("pre_abort_fall_pending");
      bus.din = 1'b1;
      k = cyc;
      tick(3);
      rest = 1'b1;
      tick(1);
      chk("abort_edge_cnt", {24'd0, bus.edge_cnt}, 0);
      chk("abort_d", {31'd0, bus.d}, 0);
      rest = 1'b0;
      // first non-reset edge is k+5; d rises on the 6th edge from there
      expect_strobe(1'b1, k + 10, 1);
      tick(10);
      chk("abort_rise_d", {31'd0, bus.d}, 1);
      drain_check("abort_pending");

      // counter wrap: 257 accepted rising edges from reset
      rest    = 1'b1;
      bus.din = 1'b0;
      tick(2);
      rest = 1'b0;
      tick(4);
      n_rise = 0;
      n_fall = 0;
      for (int i = 0; i < 257; i++) begin
         bus.din = 1'b1;
         k = cyc;
         expect_strobe(1'b1, k + 6, (i + 1) % 256);
         tick(8);
         if (i < 256) begin
            bus.din = 1'b0;
            k = cyc;
            expect_strobe(1'b0, k + 6, (i + 1) % 256);
            tick(8);
         end
      end
      tick(10);
      chk("wrap_edge_cnt", {24'd0, bus.edge_cnt}, 1);
      chk("wrap_rise_count", n_rise, 257);
      chk("wrap_fall_count", n_fall, 256);
      chk("wrap_d", {31'd0, bus.d}, 1);
      drain_check("wrap_pending");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
